// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port (I) and
// the load/store port (D). One transaction is in flight at a time: it is
// captured in IDLE, presented to memory in ISSUE and acknowledged in RESP.
// D has priority; a streak counter bounds how long a pending fetch can be
// starved. An optional timeout aborts a transaction whose memory never acks.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 0
) (
   input  logic                clk,
   input  logic                rst,
   // instruction-fetch requester
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ack,
   output logic                i_err,
   // load/store requester
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                d_err,
   // memory side
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   // status
   output logic                busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int SW     = $clog2(MAX_D_STREAK + 1);
   localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [TW-1:0] TLAST      = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic          TO_EN      = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t        state;
   logic          win_d;    // owner of the transaction in flight: 1 = D, 0 = I
   logic [SW-1:0] streak;   // consecutive D grants taken while I was waiting
   logic [TW-1:0] tcnt;     // ISSUE cycles elapsed without mem_ack

   logic grant;
   logic grant_d;
   logic timed_out;
   logic done;

   // Streak update on a grant: only a D grant that bypasses a waiting fetch
   // extends the streak; anything else restarts it. Saturates at the limit.
   function automatic logic [SW-1:0] streak_next(input logic [SW-1:0] cur,
                                                 input logic          is_d,
                                                 input logic          i_waiting);
      logic [SW-1:0] nxt;
      if (!is_d || !i_waiting)
         nxt = '0;
      else if (cur >= STREAK_MAX)
         nxt = STREAK_MAX;
      else
         nxt = cur + 1'b1;
      return nxt;
   endfunction

   // Read data returned to the winner: memory data on a real ack, zero on abort.
   function automatic logic [DATA_W-1:0] resp_data(input logic          acked,
                                                   input logic [DATA_W-1:0] rd);
      return acked ? rd : '0;
   endfunction

   // Arbitration and completion decode for the current cycle.
   always_comb begin
      grant     = (state == IDLE) && (i_req || d_req);
      grant_d   = d_req && !(i_req && (streak == STREAK_MAX));
      timed_out = TO_EN && (tcnt == TLAST);
      done      = (state == ISSUE) && (mem_ack || timed_out);
   end

   // Sequencer: IDLE -> ISSUE on a grant, ISSUE -> RESP on ack or timeout,
   // RESP -> IDLE unconditionally so a requester can drop req on its ack edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mem_req <= 1'b0;
         busy    <= 1'b0;
         win_d   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant) begin
                  state   <= ISSUE;
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
                  win_d   <= grant_d;
               end
            end
            ISSUE: begin
               if (done) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Fetch-fairness streak counter, updated only when a grant is made.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (grant) begin
         streak <= streak_next(streak, grant_d, i_req);
      end
   end

   // Timeout counter: restarts at each grant and counts ISSUE cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt <= '0;
      end else if (grant) begin
         tcnt <= '0;
      end else if ((state == ISSUE) && !done) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Capture the winner's operands; they stay stable for the whole ISSUE phase.
   // A fetch is always presented as a read with no byte enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else if (grant) begin
         if (grant_d) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
         end else begin
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wstrb <= {STRB_W{1'b0}};
         end
      end
   end

   // Completion: one-cycle ack (plus err on abort) and rdata update for the
   // winner only; the other port's rdata keeps its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_ack   <= 1'b0;
         i_err   <= 1'b0;
         d_ack   <= 1'b0;
         d_err   <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         i_ack <= 1'b0;
         i_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;
         if (done) begin
            if (win_d) begin
               d_ack   <= 1'b1;
               d_err   <= !mem_ack;
               d_rdata <= resp_data(mem_ack, mem_rdata);
            end else begin
               i_ack   <= 1'b1;
               i_err   <= !mem_ack;
               i_rdata <= resp_data(mem_ack, mem_rdata);
            end
         end
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequencer/arbiter sharing the single-ported unified memory between the instruction-fetch requester (I) and the load/store requester (D) of the RV32 core.
- Captures one request at a time, drives the memory handshake, returns read data and a one-cycle ack to the winner.
- Data port has priority; a streak counter guarantees fetch progress.
- Optional timeout terminates hung transactions with an error flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_D_STREAK, 4, maximum consecutive D grants while I is pending; must be ≥1.
- TIMEOUT, 0, cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data; valid while i_ack is high.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  high with i_ack when the transaction timed out.
- d_req  in  1  data request; held with all d_* inputs until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_wstrb  in  DATA_W/8  byte enables for writes.
- d_rdata  out  DATA_W  load data; valid while d_ack is high.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  high with d_ack on timeout.
- mem_req  out  1  memory request; held until mem_ack or timeout.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the granted request.
- mem_rdata  in  DATA_W  read data; sampled when mem_ack is high.
- mem_ack  in  1  memory completion; ignored while mem_req is low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including mem_req, acks, errs, rdata, mem_* and busy.
  - Streak counter and timeout counter clear.
- Reset mid-transaction abandons the transaction: mem_req drops the next cycle and no ack is issued. The memory tolerates a withdrawn request.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - With no requests, stay in IDLE.
  - Otherwise select a winner, latch its operands into mem_*, and move to ISSUE.
  - I requests always present mem_we=0 and mem_wstrb=0.
- Arbitration in IDLE:
  - Only D requesting: D wins.
  - Only I requesting: I wins.
  - Both requesting: D wins unless streak==MAX_D_STREAK, in which case I wins.
- Streak counter:
  - Increments on a D grant while i_req is high.
  - Clears on any I grant, or on a D grant while i_req is low.
  - Saturates at MAX_D_STREAK.
- ISSUE:
  - mem_req=1 and mem_* stay stable.
  - On mem_ack: capture mem_rdata into the winner's rdata register and move to RESP. This is allowed in the first ISSUE cycle (zero-wait memory).
  - When TIMEOUT>0, a counter runs during ISSUE. If TIMEOUT cycles pass without mem_ack, move to RESP with rdata=0 and err=1.
- RESP:
  - Winner's ack=1 for exactly one cycle; err=1 in the same cycle on timeout.
  - mem_req=0.
  - New requests are not sampled in RESP; the state goes to IDLE next cycle. This lets the requester drop req on the ack edge without a double grant.
- Outside RESP, ack and err are 0.
- rdata registers hold their value until the next completion for that port. On a write completion, d_rdata is updated to mem_rdata.
- Latency with memory ack in its k-th ISSUE cycle (k≥1):
  - Request high at IDLE edge N.
  - mem_req high in cycles N+1 .. N+k.
  - Ack in cycle N+k+1.
  - Next grant decided at cycle N+k+2.
  - Throughput is one transaction per k+2 cycles.
- Requests deasserted before ack are a requester protocol violation; the captured transaction still completes.
- Requests arriving during ISSUE/RESP wait; no queueing beyond the level-held req.

Test Plan:
- Single I fetch, addr 0x0000_0040, memory acks in 1st ISSUE cycle with 0x0000_0013 -> mem_req high 1 cycle; i_ack high cycle N+2 with i_rdata=0x13; d_ack stays 0.
- D write, addr 0x100, wdata 0xDEADBEEF, wstrb 0b0011, memory waits 3 cycles -> mem_we=1, mem_wstrb=0011 stable for 3 cycles; d_ack one pulse at cycle N+4.
- I and D both held high continuously, MAX_D_STREAK=4, 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I…; no ack is ever issued to a port with req low.
- Both requesters drop req on their ack edge, back-to-back alternating -> no duplicate grant; each transaction takes exactly k+2 cycles.
- TIMEOUT=8, memory never acks on a D read -> mem_req high for 8 cycles, then d_ack=1 with d_err=1 and d_rdata=0; the next I request completes normally.
- rst asserted during ISSUE of an I fetch -> mem_req, busy and all acks 0 next cycle; streak=0; a fresh D request after rst is granted first.
